// File: rtl/fmac_fifo_sync_param_pkg.sv
// rtl/fmac_fifo_sync_param_pkg.sv - shared FIFO mode constants and pointer-width helper
package fmac_fifo_sync_param_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Smallest n with 2**n >= value; used to size pointers from DEPTH.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fmac_fifo_sync_param_ram.sv
// rtl/fmac_fifo_sync_param_ram.sv - simple dual-port storage with registered or combinational read
module fmac_fifo_ram
  import fmac_fifo_sync_param_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4096,
  parameter int PTR   = 12,
  parameter int FWFT  = FIFO_MODE_STD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [PTR-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [PTR-1:0]   raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write port; left without reset so it maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    logic unused_ctrl;
    assign unused_ctrl = ^{rst_n, clr, re};
    assign rdata = mem[raddr];
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;

    // Registered read: output updates only on an accepted read, cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else if (clr) begin
        rdata_q <= '0;
      end else if (re) begin
        rdata_q <= mem[raddr];
      end
    end

    assign rdata = rdata_q;
  end

endmodule

// File: rtl/fmac_fifo_sync_param.sv
// rtl/fmac_fifo_sync_param.sv - parametrised single-clock FIFO with thresholds, flush and sticky errors
module fmac_fifo_sync_param
  import fmac_fifo_sync_param_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4096,
  parameter int PTR      = clog2(DEPTH),
  parameter int FWFT     = FIFO_MODE_STD,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             flush,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PTR:0]     usedw,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [PTR:0] DEPTH_W = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] AF_W    = (PTR+1)'(AF_LEVEL);
  localparam logic [PTR:0] AE_W    = (PTR+1)'(AE_LEVEL);

  logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR:0]     usedw_q, usedw_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] ram_rdata;

  // Accepts use the registered flags; flush suppresses both requests entirely.
  assign wr_acc = wrreq & ~full_q  & ~flush;
  assign rd_acc = rdreq & ~empty_q & ~flush;

  // Next-state for pointers, occupancy and every flag, all derived from usedw_d.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usedw_d  = usedw_q;
    full_d   = full_q;
    empty_d  = empty_q;
    af_d     = af_q;
    ae_d     = ae_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      full_d   = 1'b0;
      empty_d  = 1'b1;
      af_d     = 1'b0;
      ae_d     = 1'b1;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      usedw_d = usedw_q + {{PTR{1'b0}}, wr_acc} - {{PTR{1'b0}}, rd_acc};
      full_d  = (usedw_d == DEPTH_W);
      empty_d = (usedw_d == '0);
      af_d    = (usedw_d >= AF_W);
      ae_d    = (usedw_d <= AE_W);
      ovf_d   = ovf_q | (wrreq & full_q);
      udf_d   = udf_q | (rdreq & empty_q);
    end
  end

  // Control state register with asynchronous reset to the empty condition.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fmac_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR   (PTR),
    .FWFT  (FWFT)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset_),
    .clr   (flush),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // In fall-through mode the head is masked while empty so stale memory never shows.
  assign q            = (FWFT == FIFO_MODE_FWFT && empty_q) ? '0 : ram_rdata;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign usedw        = usedw_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fmac_fifo_sync_param.sv
// tb/tb_fmac_fifo_sync_param.sv - directed bench for standard and fall-through FIFO instances
module tb_fmac_fifo_sync_param;

  logic        clk;
  logic        reset_;

  logic        a_flush, a_wrreq, a_rdreq;
  logic [31:0] a_data, a_q;
  logic        a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic [4:0]  a_usedw;

  logic        b_flush, b_wrreq, b_rdreq;
  logic [31:0] b_data, b_q;
  logic        b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [4:0]  b_usedw;

  int total = 0;
  int bad   = 0;

  fmac_fifo_sync_param #(
    .WIDTH(32), .DEPTH(16), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(3)
  ) u_std (
    .clk(clk), .reset_(reset_), .flush(a_flush), .wrreq(a_wrreq), .data(a_data),
    .rdreq(a_rdreq), .q(a_q), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .usedw(a_usedw), .overflow(a_ovf), .underflow(a_udf)
  );

  fmac_fifo_sync_param #(
    .WIDTH(32), .DEPTH(16), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(3)
  ) u_fwft (
    .clk(clk), .reset_(reset_), .flush(b_flush), .wrreq(b_wrreq), .data(b_data),
    .rdreq(b_rdreq), .q(b_q), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .usedw(b_usedw), .overflow(b_ovf), .underflow(b_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rd, fl;
    logic [31:0] d;
    logic [4:0]  uw;
    logic        fu, em, af, ae, ov, un;
    logic [31:0] q;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic wr, input logic rd, input logic fl, input logic [31:0] d,
                              input logic [4:0] uw, input logic fu, input logic em, input logic af,
                              input logic ae, input logic ov, input logic un, input logic [31:0] qq);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl; v.d = d; v.uw = uw; v.fu = fu; v.em = em;
    v.af = af; v.ae = ae; v.ov = ov; v.un = un; v.q = qq;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_wrreq = 1'b0; a_rdreq = 1'b0; a_flush = 1'b0; a_data = '0;
  endtask

  task automatic a_write(input logic [31:0] d);
    a_wrreq = 1'b1; a_data = d;
    step();
    a_idle();
  endtask

  initial begin
    reset_ = 1'b0;
    a_idle();
    b_flush = 1'b0; b_wrreq = 1'b0; b_rdreq = 1'b0; b_data = '0;

    // Vector table: underflow/flush, fill to full, overflow, drain, final flush.
    add(0, 1, 0, 32'h0, 5'd0, 0, 1, 0, 1, 0, 1, 32'h0);
    add(0, 0, 1, 32'h0, 5'd0, 0, 1, 0, 1, 0, 0, 32'h0);
    for (int k = 1; k <= 16; k++)
      add(1, 0, 0, 32'(k - 1), 5'(k), k == 16, 0, k >= 12, k <= 3, 0, 0, 32'h0);
    add(1, 0, 0, 32'h99, 5'd16, 1, 0, 1, 0, 1, 0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      int u;
      u = 15 - i;
      add(0, 1, 0, 32'h0, 5'(u), 0, u == 0, u >= 12, u <= 3, 1, 0, 32'(i));
    end
    add(0, 0, 1, 32'h0, 5'd0, 0, 1, 0, 1, 0, 0, 32'h0);

    repeat (2) @(posedge clk);
    #3;
    chk("rst usedw", 32'(a_usedw), 32'd0);
    chk("rst empty", 32'(a_empty), 32'd1);
    chk("rst full", 32'(a_full), 32'd0);
    chk("rst ae", 32'(a_ae), 32'd1);
    chk("rst af", 32'(a_af), 32'd0);
    chk("rst q", a_q, 32'h0);
    chk("rst ovf", 32'(a_ovf), 32'd0);
    chk("rst udf", 32'(a_udf), 32'd0);
    reset_ = 1'b1;
    step();

    foreach (vq[i]) begin
      a_wrreq = vq[i].wr; a_rdreq = vq[i].rd; a_flush = vq[i].fl; a_data = vq[i].d;
      step();
      chk($sformatf("vec%0d usedw", i), 32'(a_usedw), 32'(vq[i].uw));
      chk($sformatf("vec%0d full", i), 32'(a_full), 32'(vq[i].fu));
      chk($sformatf("vec%0d empty", i), 32'(a_empty), 32'(vq[i].em));
      chk($sformatf("vec%0d af", i), 32'(a_af), 32'(vq[i].af));
      chk($sformatf("vec%0d ae", i), 32'(a_ae), 32'(vq[i].ae));
      chk($sformatf("vec%0d ovf", i), 32'(a_ovf), 32'(vq[i].ov));
      chk($sformatf("vec%0d udf", i), 32'(a_udf), 32'(vq[i].un));
      chk($sformatf("vec%0d q", i), a_q, vq[i].q);
    end
    a_idle();

    // Steady-state read+write at usedw=5 across several pointer wraps.
    for (int k = 0; k < 5; k++) a_write(32'(100 + k));
    chk("rw pre usedw", 32'(a_usedw), 32'd5);
    for (int i = 0; i < 40; i++) begin
      a_wrreq = 1'b1; a_rdreq = 1'b1; a_data = 32'(105 + i);
      step();
      chk($sformatf("rw%0d usedw", i), 32'(a_usedw), 32'd5);
      chk($sformatf("rw%0d q", i), a_q, 32'(100 + i));
    end
    a_idle();
    for (int j = 0; j < 5; j++) begin
      a_rdreq = 1'b1;
      step();
      chk($sformatf("rw drain%0d q", j), a_q, 32'(140 + j));
    end
    a_idle();
    chk("rw drained empty", 32'(a_empty), 32'd1);
    chk("rw no errors", 32'({a_ovf, a_udf}), 32'd0);

    // Write while full together with an accepted read: read happens, write is dropped.
    for (int k = 0; k < 16; k++) a_write(32'(200 + k));
    chk("full before", 32'(a_full), 32'd1);
    a_wrreq = 1'b1; a_rdreq = 1'b1; a_data = 32'hDEAD;
    step();
    a_idle();
    chk("full wr+rd usedw", 32'(a_usedw), 32'd15);
    chk("full wr+rd ovf", 32'(a_ovf), 32'd1);
    chk("full wr+rd q", a_q, 32'd200);
    for (int j = 1; j < 16; j++) begin
      a_rdreq = 1'b1;
      step();
      chk($sformatf("full drain%0d q", j), a_q, 32'(200 + j));
    end
    a_idle();
    chk("full drain empty", 32'(a_empty), 32'd1);

    // Flush at usedw=7 with concurrent write and read requests.
    a_flush = 1'b1;
    step();
    a_idle();
    for (int k = 0; k < 7; k++) a_write(32'(300 + k));
    a_rdreq = 1'b1;
    step();
    a_idle();
    chk("pre flush q", a_q, 32'd300);
    chk("pre flush usedw", 32'(a_usedw), 32'd6);
    a_write(32'd307);
    chk("pre flush usedw7", 32'(a_usedw), 32'd7);
    a_flush = 1'b1; a_wrreq = 1'b1; a_rdreq = 1'b1; a_data = 32'h77;
    step();
    a_idle();
    chk("flush usedw", 32'(a_usedw), 32'd0);
    chk("flush empty", 32'(a_empty), 32'd1);
    chk("flush ovf", 32'(a_ovf), 32'd0);
    chk("flush udf", 32'(a_udf), 32'd0);
    chk("flush q", a_q, 32'h0);
    chk("flush ae", 32'(a_ae), 32'd1);

    // Fall-through instance: head visible as soon as empty drops.
    chk("fwft idle q", b_q, 32'h0);
    b_wrreq = 1'b1; b_data = 32'hA5A5_A5A5;
    step();
    b_wrreq = 1'b0;
    chk("fwft empty fall", 32'(b_empty), 32'd0);
    chk("fwft q head", b_q, 32'hA5A5_A5A5);
    chk("fwft usedw1", 32'(b_usedw), 32'd1);
    b_rdreq = 1'b1;
    step();
    b_rdreq = 1'b0;
    chk("fwft empty rise", 32'(b_empty), 32'd1);
    chk("fwft usedw0", 32'(b_usedw), 32'd0);
    b_wrreq = 1'b1; b_data = 32'h11;
    step();
    b_data = 32'h22;
    step();
    b_wrreq = 1'b0;
    chk("fwft q first", b_q, 32'h11);
    b_rdreq = 1'b1;
    step();
    b_rdreq = 1'b0;
    chk("fwft q second", b_q, 32'h22);
    chk("fwft not empty", 32'(b_empty), 32'd0);
    chk("fwft no udf", 32'(b_udf), 32'd0);

    // Asynchronous reset in the middle of a write burst.
    for (int k = 0; k < 3; k++) a_write(32'(400 + k));
    a_rdreq = 1'b1;
    step();
    a_idle();
    chk("burst q", a_q, 32'd400);
    a_wrreq = 1'b1; a_data = 32'h55;
    step();
    #2;
    reset_ = 1'b0;
    #1;
    chk("async rst usedw", 32'(a_usedw), 32'd0);
    chk("async rst empty", 32'(a_empty), 32'd1);
    chk("async rst q", a_q, 32'h0);
    chk("async rst ae", 32'(a_ae), 32'd1);
    chk("async rst fwft empty", 32'(b_empty), 32'd1);
    chk("async rst fwft usedw", 32'(b_usedw), 32'd0);
    a_idle();
    #1;
    reset_ = 1'b1;
    step();
    chk("post rst usedw", 32'(a_usedw), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmac_fifo_sync_param.md
Name: fmac_fifo_sync_param

Overview:
Parametrised single-clock FIFO, successor to the fixed 4Kx32 packet-control FIFO wrapper in the LMAC core. It is generic in width and depth and selectable between standard and first-word-fall-through read modes. It adds programmable almost-full/almost-empty flags, a synchronous flush, sticky overflow/underflow error flags, and a true occupancy count that can represent DEPTH. It is used for packet-control and descriptor buffering inside the MAC datapath, without a vendor IP core.

Parameters:
WIDTH, 32, data width in bits
DEPTH, 4096, number of entries; must be a power of two, at least 4
PTR, 12, log2(DEPTH); pointer width
FWFT, 0, read mode: 0 = standard (q valid the cycle after rdreq), 1 = first-word-fall-through
AF_LEVEL, DEPTH-4, almost_full asserts when usedw >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserts when usedw <= AE_LEVEL

Ports:
clk  in  1  single clock for write and read
reset_  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of all contents and error flags
wrreq  in  1  write request
data  in  WIDTH  write data
rdreq  in  1  read request
q  out  WIDTH  read data
full  out  1  usedw == DEPTH
empty  out  1  usedw == 0
almost_full  out  1  usedw >= AF_LEVEL
almost_empty  out  1  usedw <= AE_LEVEL
usedw  out  PTR+1  current occupancy, range 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (reset_=0, asynchronous):
  - wr_ptr, rd_ptr and usedw = 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - q=0, overflow=0, underflow=0.
- Accept rules:
  - wr_acc = wrreq & ~full.
  - rd_acc = rdreq & ~empty.
  - Both are evaluated on the registered flags of the current cycle.
- Write while full: data is dropped, overflow is set, pointers are unchanged. This holds even if rdreq is accepted in the same cycle; a full FIFO never does a same-cycle write.
- Read while empty: q is unchanged, underflow is set.
- Simultaneous wr_acc and rd_acc (neither full nor empty): usedw is unchanged and both pointers advance.
- Count update: usedw_next = usedw + wr_acc - rd_acc, computed at PTR+1 bits.
  - All flags are registered and derived from usedw_next, so they are valid in the cycle after the accepted operation.
- Pointers: PTR bits wide, increment on accept, wrap naturally from DEPTH-1 to 0. There is no special case at the wrap point.
- Memory: mem[wr_ptr] <= data on wr_acc.
- FWFT=0 (standard mode):
  - q <= mem[rd_ptr] on rd_acc, so data appears 1 cycle after rdreq.
  - q holds its value otherwise.
- FWFT=1 (first-word-fall-through):
  - q = mem[rd_ptr] (combinational read); rdreq acts as the acknowledge of the current head.
  - q is only meaningful while empty=0.
  - The first write into an empty FIFO is visible on q when empty falls, 1 cycle after wrreq.
- Flush:
  - Clears the pointers, usedw, overflow and underflow, and sets the flags to their reset values.
  - Has priority over wrreq and rdreq in the same cycle; those requests are ignored and raise no error flag.
  - In FWFT=0 mode, q is cleared to 0.
- Reset mid-operation: all state returns to reset values immediately. Memory contents are don't-care and are never observed while empty=1.
- Threshold flags follow usedw in both directions, with no hysteresis.

Decomposition:
- A shared package holds the FIFO mode constants (FIFO_MODE_STD=0, FIFO_MODE_FWFT=1) and a clog2 function so that PTR is derived consistently across instances.
- One sub-module, fmac_fifo_ram (simple dual-port RAM: write port plus registered or combinational read, selected by FWFT), keeps storage inferable as block RAM or distributed RAM.
- Control, counting and flags stay in the top module.

Test Plan:
- DEPTH=16, FWFT=0: write 16 words 0x0..0xF, then one more write.
  - full rises the cycle after the 16th write; usedw=16.
  - The 17th write sets overflow=1 and usedw stays 16.
  - Reading 16 words returns 0x0..0xF, each 1 cycle after its rdreq.
- Read from an empty FIFO after reset: underflow=1, q=0, usedw=0, empty stays 1. A following flush clears underflow.
- Simultaneous read and write with usedw=5 for 40 cycles: usedw stays 5 and the pointers wrap twice with no data corruption. The readback sequence matches the write sequence.
- FWFT=1: write 0xA5A5A5A5 into an empty FIFO.
  - empty falls after 1 cycle with q=0xA5A5A5A5 already valid, before any rdreq.
  - rdreq pops it and empty rises the next cycle.
- AF_LEVEL=12, AE_LEVEL=3: fill to 12, then drain to 3.
  - almost_full rises as usedw goes 11->12 and falls at 12->11.
  - almost_empty rises as usedw goes 4->3.
- With usedw=7, assert flush together with wrreq and rdreq: next cycle usedw=0, empty=1, overflow=underflow=0. Assert reset_=0 mid-burst: all outputs return to reset values asynchronously.
